// File: rtl/sampler_drum_voice_reader_if.sv
// sampler_drum_voice_reader_if: word read port between a drum voice and sample memory
interface sampler_drum_voice_reader_if;
    logic        mem_rd;
    logic [19:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    modport master (output mem_rd, mem_addr, input mem_rdata, mem_rvalid);
    modport slave  (input mem_rd, mem_addr, output mem_rdata, mem_rvalid);
endinterface

// File: rtl/sampler_drum_voice_reader.sv
// sampler_drum_voice_reader: one-shot drum voice that streams sample words to the mixer on sample ticks
module sampler_drum_voice_reader #(
    parameter logic [19:0] SAMPLE_LEN = 20'h08000,
    parameter bit          ONE_SHOT   = 1'b1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [19:0]                        note_addr,
    input  logic                               invalid_note,
    input  logic                               sample_tick,
    sampler_drum_voice_reader_if.master        mem,
    output logic [15:0]                        audio_out,
    output logic                               audio_valid,
    output logic                               busy,
    output logic                               underrun
);
    typedef enum logic [1:0] {IDLE, FETCH, WAIT_TICK} state_t;
    state_t      state;
    logic        prev_invalid, pend, rel_pend, zero_pend;
    logic [19:0] prev_addr, base, offset, pend_addr, next_off, load_addr;
    logic [15:0] data_buf;
    logic        trig, stop, quit, load;
    assign trig      = !invalid_note && (prev_invalid || note_addr != prev_addr);
    assign stop      = !ONE_SHOT && invalid_note && !prev_invalid;
    assign quit      = (rel_pend && !trig) || stop;
    assign next_off  = offset + 20'd1;
    assign busy      = state != IDLE;
    // a read in flight is never aborted: a retrigger reloads only once it completes
    assign load      = (trig && state != FETCH) ||
                       (state == FETCH && mem.mem_rvalid && !quit && (pend || trig));
    assign load_addr = (state == FETCH && !trig) ? pend_addr : note_addr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            prev_invalid <= 1'b1;
            prev_addr    <= '0;
            base         <= '0;
            offset       <= '0;
            pend         <= 1'b0;
            pend_addr    <= '0;
            rel_pend     <= 1'b0;
            zero_pend    <= 1'b0;
            data_buf     <= '0;
            mem.mem_rd   <= 1'b0;
            mem.mem_addr <= '0;
            audio_out    <= '0;
            audio_valid  <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            prev_invalid <= invalid_note;
            prev_addr    <= note_addr;
            audio_valid  <= 1'b0;
            underrun     <= 1'b0;
            case (state)
                IDLE: begin
                    if (zero_pend && sample_tick) begin
                        audio_out   <= '0;
                        audio_valid <= 1'b1;
                        zero_pend   <= 1'b0;
                    end
                end
                FETCH: begin
                    underrun <= sample_tick;
                    if (trig) begin
                        pend      <= 1'b1;
                        pend_addr <= note_addr;
                        rel_pend  <= 1'b0;
                    end else if (stop) rel_pend <= 1'b1;
                    if (mem.mem_rvalid) begin
                        pend       <= 1'b0;
                        rel_pend   <= 1'b0;
                        mem.mem_rd <= 1'b0;
                        data_buf   <= mem.mem_rdata;
                        state      <= quit ? IDLE : WAIT_TICK;
                        zero_pend  <= quit;
                    end
                end
                WAIT_TICK: begin
                    if (stop) begin
                        state     <= IDLE;
                        zero_pend <= 1'b1;
                    end else if (sample_tick && !trig) begin
                        audio_out   <= data_buf;
                        audio_valid <= 1'b1;
                        offset      <= next_off;
                        if (next_off == SAMPLE_LEN) begin
                            state     <= IDLE;
                            zero_pend <= 1'b1;
                        end else begin
                            mem.mem_addr <= base + next_off;
                            mem.mem_rd   <= 1'b1;
                            state        <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            if (load) begin
                base         <= load_addr;
                offset       <= '0;
                mem.mem_addr <= load_addr;
                mem.mem_rd   <= 1'b1;
                state        <= FETCH;
                zero_pend    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sampler_drum_voice_reader.sv
// tb_sampler_drum_voice_reader: directed checks of a one-shot and a key-release voice sharing one stimulus
module tb_sampler_drum_voice_reader;
    logic        clk = 1'b0, rst_n = 1'b0, invalid_note = 1'b1, sample_tick = 1'b0;
    logic [19:0] note_addr = '0;
    logic [15:0] a_out, b_out;
    logic        a_valid, a_busy, a_und, b_valid, b_busy, b_und;
    int          n_cmp = 0, n_bad = 0, lat = 3, cnt_a = 0, cnt_b = 0, tcnt = 0, und_cnt = 0;
    bit          stray = 1'b0;
    logic [15:0] aq[$], bq[$], uq[$];
    logic [19:0] adq[$];
    logic [15:0] exp_basic [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0000};
    logic [19:0] exp_wrap  [4] = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001};
    logic [15:0] exp_wdat  [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    sampler_drum_voice_reader_if m_a();
    sampler_drum_voice_reader_if m_b();

    sampler_drum_voice_reader #(.SAMPLE_LEN(20'd4), .ONE_SHOT(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .note_addr(note_addr), .invalid_note(invalid_note),
        .sample_tick(sample_tick), .mem(m_a), .audio_out(a_out), .audio_valid(a_valid),
        .busy(a_busy), .underrun(a_und));
    sampler_drum_voice_reader #(.SAMPLE_LEN(20'd4), .ONE_SHOT(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .note_addr(note_addr), .invalid_note(invalid_note),
        .sample_tick(sample_tick), .mem(m_b), .audio_out(b_out), .audio_valid(b_valid),
        .busy(b_busy), .underrun(b_und));

    initial forever #5 clk = ~clk;

    function automatic logic [15:0] mem_data(logic [19:0] a);
        logic [15:0] k;
        k = {14'd0, a[1:0]} + 16'd1;
        return (a[19:2] == 18'h1E48C) ? k * 16'h1111 : a[15:0];
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk); #1;
        tcnt = (tcnt + 1) % 20;
        sample_tick = (tcnt == 0);
    end

    initial forever begin
        @(posedge clk); #1;
        m_a.mem_rvalid = 1'b0;
        if (stray) begin
            m_a.mem_rvalid = 1'b1;
            m_a.mem_rdata  = 16'hDEAD;
            stray = 1'b0;
        end else if (!rst_n || !m_a.mem_rd) cnt_a = 0;
        else begin
            cnt_a++;
            if (cnt_a >= lat) begin
                m_a.mem_rvalid = 1'b1;
                m_a.mem_rdata  = mem_data(m_a.mem_addr);
                cnt_a = 0;
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        m_b.mem_rvalid = 1'b0;
        if (!rst_n || !m_b.mem_rd) cnt_b = 0;
        else begin
            cnt_b++;
            if (cnt_b >= lat) begin
                m_b.mem_rvalid = 1'b1;
                m_b.mem_rdata  = mem_data(m_b.mem_addr);
                cnt_b = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (a_valid) aq.push_back(a_out);
        if (b_valid) bq.push_back(b_out);
        if (m_a.mem_rvalid) adq.push_back(m_a.mem_addr);
        if (a_und) begin
            und_cnt++;
            uq.push_back(a_out);
        end
    end

    task automatic start(logic [19:0] addr, int l);
        invalid_note = 1'b1;
        repeat (3) @(negedge clk);
        aq.delete(); bq.delete(); uq.delete(); adq.delete();
        und_cnt = 0;
        lat = l;
        note_addr = addr;
        invalid_note = 1'b0;
    endtask

    task automatic wait_valid(string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_valid && n < 500);
        check(tag, a_valid, 1);
    endtask

    initial begin
        m_a.mem_rvalid = 1'b0; m_a.mem_rdata = '0;
        m_b.mem_rvalid = 1'b0; m_b.mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_audio", a_out, 0);
        check("rst_valid", a_valid, 0);
        check("rst_busy", a_busy, 0);
        check("rst_und", a_und, 0);
        check("rst_rd", m_a.mem_rd, 0);
        check("rst_addr", m_a.mem_addr, 0);
        rst_n = 1'b1;

        start(20'h79230, 3);
        @(negedge clk);
        check("trig_rd", m_a.mem_rd, 1);
        check("trig_addr", m_a.mem_addr, 20'h79230);
        check("trig_busy", a_busy, 1);
        repeat (300) @(negedge clk);
        check("basic_cnt", aq.size(), 5);
        for (int i = 0; i < 5; i++) check($sformatf("basic_w%0d", i), aq[i], exp_basic[i]);
        for (int i = 0; i < 4; i++) check($sformatf("basic_a%0d", i), adq[i], 20'h79230 + i);
        check("basic_idle", a_busy, 0);

        start(20'hFFFFE, 3);
        repeat (300) @(negedge clk);
        for (int i = 0; i < 4; i++) check($sformatf("wrap_a%0d", i), adq[i], exp_wrap[i]);
        for (int i = 0; i < 4; i++) check($sformatf("wrap_w%0d", i), aq[i], exp_wdat[i]);

        start(20'h60EE0, 5);
        wait_valid("retrig_first");
        check("retrig_rd", m_a.mem_rd, 1);
        note_addr = 20'h68FB0;
        repeat (300) @(negedge clk);
        check("retrig_cnt", aq.size(), 6);
        check("retrig_w0", aq[0], 16'h0EE0);
        check("retrig_w1", aq[1], 16'h8FB0);
        check("retrig_w4", aq[4], 16'h8FB3);
        check("retrig_w5", aq[5], 16'h0000);
        check("retrig_a1", adq[1], 20'h60EE1);
        check("retrig_a2", adq[2], 20'h68FB0);

        start(20'h79230, 30);
        repeat (400) @(negedge clk);
        check("und_cnt", aq.size(), 5);
        for (int i = 0; i < 5; i++) check($sformatf("und_w%0d", i), aq[i], exp_basic[i]);
        check("und_pulses", und_cnt >= 4, 1);
        check("und_hold", uq[uq.size() - 1], 16'h3333);

        start(20'h79230, 3);
        wait_valid("rel_first");
        invalid_note = 1'b1;
        repeat (300) @(negedge clk);
        check("rel_os_cnt", aq.size(), 5);
        check("rel_os_w3", aq[3], 16'h4444);
        check("rel_k_cnt", bq.size(), 2);
        check("rel_k_w0", bq[0], 16'h1111);
        check("rel_k_w1", bq[1], 16'h0000);
        check("rel_k_idle", b_busy, 0);

        start(20'h79230, 10);
        wait_valid("arst_first");
        #2 rst_n = 1'b0;
        #1;
        check("arst_audio", a_out, 0);
        check("arst_rd", m_a.mem_rd, 0);
        check("arst_busy", a_busy, 0);
        check("arst_addr", m_a.mem_addr, 0);
        invalid_note = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b1;
        repeat (60) @(negedge clk);
        check("arst_cnt", aq.size(), 1);
        check("arst_idle", a_busy, 0);
        check("arst_rd2", m_a.mem_rd, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sampler_drum_voice_reader.md
Name: sampler_drum_voice_reader

Overview:
- Playback engine on the consuming side of the drum keymapper. It receives a sample start address (note_addr) plus an invalid_note flag, and detects note onsets.
- On each onset it reads the one-shot drum sample word-by-word from sample memory through a request/valid read port.
- Each sample word is presented on a 16-bit audio output, aligned to the system sample-rate tick.
- Sits between the keymapper and the mixer/DAC path; one instance per voice.

Parameters:
- SAMPLE_LEN, 20'h08000, number of 16-bit words played per hit; sim benches override to 4.
- ONE_SHOT, 1, 1 = play to end regardless of key release; 0 = stop when invalid_note rises.

Ports:
- Clk  input  1  system clock
- Reset_n  input  1  asynchronous active-low reset
- note_addr  input  20  sample start word address from keymapper
- invalid_note  input  1  1 = no mapped key pressed
- sample_tick  input  1  single-cycle pulse at audio sample rate
- mem_rd  output  1  read request, held until mem_rvalid
- mem_addr  output  20  read word address, stable while mem_rd=1
- mem_rdata  input  16  read data, valid with mem_rvalid
- mem_rvalid  input  1  single-cycle read completion
- audio_out  output  16  signed sample to mixer
- audio_valid  output  1  1-cycle pulse when audio_out updates
- busy  output  1  voice active (any state except IDLE)
- underrun  output  1  1-cycle pulse: tick arrived before fetch completed

Behaviour:
- Reset (async, Reset_n=0): state=IDLE; mem_rd=0, mem_addr=0, audio_out=0, audio_valid=0, busy=0, underrun=0. Internal: prev_invalid=1, prev_addr=0, offset=0, base=0, pend=0.
- Onset detect (registered every cycle):
  - trig = !invalid_note && (prev_invalid || note_addr != prev_addr).
  - prev_* update every cycle.
- States:
  - IDLE: on trig, latch base=note_addr, set offset=0, go FETCH.
  - FETCH: mem_rd=1, mem_addr=base+offset (20-bit wrap mod 2^20).
    - On mem_rvalid: buf=mem_rdata; deassert mem_rd the next cycle; go WAIT_TICK.
    - A sample_tick seen while in FETCH pulses underrun the next cycle. In that case audio_out holds, offset does not advance, and the tick is dropped.
  - WAIT_TICK: on sample_tick, with registered 1-cycle latency:
    - audio_out=buf, audio_valid=1, offset=offset+1.
    - If offset+1==SAMPLE_LEN, go IDLE. Otherwise go FETCH.
- End of sample:
  - On return to IDLE, audio_out=0 on the next sample_tick (audio_valid pulses once with 0). After that, no further pulses.
- Retrigger:
  - trig in WAIT_TICK: restart immediately, with base=note_addr and offset=0, and go FETCH. buf is discarded.
  - trig in FETCH: set pend=1 and keep the request outstanding, because a memory request is never aborted. On mem_rvalid the data is discarded, base/offset reload, and the block re-enters FETCH. pend is cleared.
  - trig in the same cycle as a sample_tick in WAIT_TICK: the retrigger wins and no audio_valid is issued.
- Release: with ONE_SHOT=0, a rise of invalid_note ends playback.
  - In WAIT_TICK: go to IDLE immediately.
  - In FETCH: the outstanding read is completed first, then the block goes to IDLE.
- Latency:
  - trig to mem_rd is 1 cycle.
  - First audio_valid occurs on the first sample_tick after the first mem_rvalid.
- Reset mid-transaction: all state is cleared. A mem_rvalid arriving after reset is ignored in IDLE.
- busy=1 in FETCH and WAIT_TICK.

Test Plan:
- Basic hit, SAMPLE_LEN=4:
  - Stimulus: invalid_note 1->0, note_addr=20'h79230. Memory returns 0x1111, 0x2222, 0x3333, 0x4444 at addresses 79230..79233. Ticks every 20 cycles.
  - Required: exactly 4 audio_valid pulses with those values, then one pulse with 0, then busy=0.
- Wrap:
  - Stimulus: note_addr=20'hFFFFE, SAMPLE_LEN=4.
  - Required: mem_addr sequence FFFFE, FFFFF, 00000, 00001.
- Retrigger during FETCH:
  - Stimulus: playing 20'h60ee0; change note_addr to 20'h68fb0 while mem_rd=1 with memory delaying rvalid by 5 cycles.
  - Required: the old read completes and its data is never output. The next mem_addr is 68fb0, and audio restarts from the 68fb0 data.
- Underrun:
  - Stimulus: memory latency 30 cycles with ticks every 20.
  - Required: underrun pulses, audio_out holds its previous value, offset does not skip, and all 4 words are eventually output in order.
- Release:
  - With ONE_SHOT=1, invalid_note returns to 1 after the first word: playback continues to completion.
  - With ONE_SHOT=0, same stimulus: the block returns to IDLE with no further data words.
- Async reset:
  - Stimulus: Reset_n=0 mid-FETCH, between clock edges.
  - Required: all outputs 0 immediately; a stray mem_rvalid after release produces no output.
